// File: rtl/microwave_sequencer.sv
// Microwave magnetron sequencer: BCD MM:SS keypad entry, one-second countdown, five-state cook FSM with door interlock.
// Latency: a key event updates state two edges after the key falls; digit entry updates the display on the sampling edge.
// Backpressure: none; all inputs are levels or one-cycle strobes; mag_on is gated combinationally by door_closed.
//
// Ports:
//   clk, rst (sync, active-high)          - clock / reset
//   startn, stopn, clearn (active-low)    - keys, falling edge of the registered value is the event
//   door_closed                            - 1 = door latched
//   digit_valid, digit[3:0]                - keypad strobe + BCD value (>9 ignored)
//   mag_on, timer_done                     - magnetron enable, done indicator
//   min_tens/min_ones/sec_tens/sec_ones    - remaining time in BCD
//   state[2:0]                             - IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
module microwave_sequencer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       mag_on,
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);

    localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [3:0]    r_mt, r_mo, r_st, r_so;
    logic [TW-1:0] r_tick;
    logic          r_startn_q, r_startn_p;
    logic          r_stopn_q,  r_stopn_p;
    logic          r_clearn_q, r_clearn_p;

    logic          w_start_ev, w_stop_ev, w_clear_ev;
    logic          w_digit_ok, w_term, w_zero, w_last;
    logic [3:0]    w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic [2:0]    w_nxt_state;
    logic [3:0]    w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;

    // Event = registered key was high last cycle and is low now; a held key yields one event.
    assign w_start_ev = r_startn_p & ~r_startn_q;
    assign w_stop_ev  = r_stopn_p  & ~r_stopn_q;
    assign w_clear_ev = r_clearn_p & ~r_clearn_q;

    assign w_digit_ok = digit_valid && (digit <= 4'd9);
    assign w_term     = (r_state == S_COOK) && (r_tick == TICK_LAST);
    assign w_zero     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
    // 00:01 is the only value whose decrement lands on 00:00.
    assign w_last     = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd1);

    // One-second BCD decrement with borrow chain; seconds wrap to 59, minutes ones to 9.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so;
        if (r_so != 4'd0) begin
            w_dec_so = r_so - 4'd1;
        end else if (r_st != 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 4'd1;
        end else begin
            w_dec_so = 4'd9;
            w_dec_st = 4'd5;
            if (r_mo != 4'd0) begin
                w_dec_mo = r_mo - 4'd1;
            end else begin
                w_dec_mo = 4'd9;
                w_dec_mt = r_mt - 4'd1;
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mt    = r_mt;
        w_nxt_mo    = r_mo;
        w_nxt_st    = r_st;
        w_nxt_so    = r_so;
        if (w_clear_ev || r_state > S_DONE
                || (r_state == S_DONE && w_stop_ev)) begin
            w_nxt_state = S_IDLE;
            w_nxt_mt    = 4'd0;
            w_nxt_mo    = 4'd0;
            w_nxt_st    = 4'd0;
            w_nxt_so    = 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_SET: begin
                    if (w_digit_ok) begin
                        {w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} = {r_mo, r_st, r_so, digit};
                        if (r_state == S_IDLE && digit != 4'd0)
                            w_nxt_state = S_SET;
                    end
                    // A zero time cannot be cooked; it finishes immediately instead.
                    if (r_state == S_SET && w_start_ev && door_closed)
                        w_nxt_state = w_zero ? S_DONE : S_COOK;
                end
                S_COOK: begin
                    // Decrement still lands when stop/door-open coincides with the terminal tick.
                    if (w_term) begin
                        w_nxt_mt = w_dec_mt;
                        w_nxt_mo = w_dec_mo;
                        w_nxt_st = w_dec_st;
                        w_nxt_so = w_dec_so;
                    end
                    if (w_stop_ev || !door_closed)
                        w_nxt_state = S_PAUSE;
                    else if (w_term && w_last)
                        w_nxt_state = S_DONE;
                end
                S_PAUSE: begin
                    if (w_start_ev && door_closed)
                        w_nxt_state = w_zero ? S_DONE : S_COOK;
                end
                default: begin  // S_DONE: fresh entry replaces the finished time
                    if (w_digit_ok) begin
                        w_nxt_state = S_SET;
                        {w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} = {12'd0, digit};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mt       <= 4'd0;
            r_mo       <= 4'd0;
            r_st       <= 4'd0;
            r_so       <= 4'd0;
            r_tick     <= '0;
            r_startn_q <= 1'b1;
            r_startn_p <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_stopn_p  <= 1'b1;
            r_clearn_q <= 1'b1;
            r_clearn_p <= 1'b1;
        end else begin
            r_state    <= w_nxt_state;
            r_mt       <= w_nxt_mt;
            r_mo       <= w_nxt_mo;
            r_st       <= w_nxt_st;
            r_so       <= w_nxt_so;
            r_startn_q <= startn;
            r_startn_p <= r_startn_q;
            r_stopn_q  <= stopn;
            r_stopn_p  <= r_stopn_q;
            r_clearn_q <= clearn;
            r_clearn_p <= r_clearn_q;
            // Tick phase is kept across PAUSE so a resumed cook continues mid-second.
            if (w_nxt_state == S_IDLE || w_nxt_state == S_SET)
                r_tick <= '0;
            else if (r_state == S_COOK)
                r_tick <= w_term ? '0 : r_tick + 1'b1;
        end
    end

    assign mag_on     = (r_state == S_COOK) && door_closed;
    assign timer_done = (r_state == S_DONE);
    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign state      = r_state;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer with TICKS_PER_SEC = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Display is compared as a 16-bit BCD word {min_tens,min_ones,sec_tens,sec_ones}.
module tb_microwave_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic       door_closed = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on, timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic [15:0] disp;

    int n_cmp = 0;
    int n_bad = 0;

    microwave_sequencer #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .digit_valid(digit_valid), .digit(digit),
        .mag_on(mag_on), .timer_done(timer_done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .state(state)
    );

    always #5 clk = ~clk;
    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
    endtask

    // Drive start low and return after the edge where the state reacts (two edges).
    task automatic start_go();
        startn = 1'b0;
        step();
        step();
    endtask

    task automatic clear_go();
        clearn = 1'b0;
        step();
        step();
        clearn = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_seq [3];
        logic [15:0] prev;
        int n_mag;
        int idx;

        // Reset and idle behaviour
        step();
        step();
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_disp", 32'(disp), 32'h0000);
        chk("rst_mag", 32'(mag_on), 32'd0);
        chk("rst_done", 32'(timer_done), 32'd0);
        door_closed = 1'b1;
        start_go();
        startn = 1'b1;
        step();
        chk("idle_start_ignored", 32'(state), 32'd0);

        // Entry 0,0,0,3 and a full 3-second cook
        key_digit(4'd0);
        chk("idle_digit0", 32'(state), 32'd0);
        key_digit(4'd0);
        key_digit(4'd0);
        key_digit(4'd3);
        chk("set_state", 32'(state), 32'd1);
        chk("set_disp", 32'(disp), 32'h0003);
        start_go();
        startn = 1'b1;
        chk("cook_state", 32'(state), 32'd2);
        exp_seq = '{16'h0002, 16'h0001, 16'h0000};
        prev  = disp;
        n_mag = 0;
        idx   = 0;
        for (int c = 0; c < 100 && state != 3'd4; c++) begin
            if (mag_on) n_mag++;
            step();
            if (disp != prev) begin
                if (idx < 3) chk("cook_disp_step", 32'(disp), 32'(exp_seq[idx]));
                idx++;
                prev = disp;
            end
        end
        chk("cook_mag_cycles", 32'(n_mag), 32'd12);
        chk("cook_disp_changes", 32'(idx), 32'd3);
        chk("done_state", 32'(state), 32'd4);
        chk("done_flag", 32'(timer_done), 32'd1);
        chk("done_mag", 32'(mag_on), 32'd0);

        // Digit in DONE starts a fresh entry
        key_digit(4'd7);
        chk("done_digit_state", 32'(state), 32'd1);
        chk("done_digit_disp", 32'(disp), 32'h0007);
        clear_go();
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_disp", 32'(disp), 32'h0000);

        // Minute borrow 01:00 -> 00:59
        key_digit(4'd1);
        key_digit(4'd0);
        key_digit(4'd0);
        start_go();
        startn = 1'b1;
        repeat (4) step();
        chk("borrow_min", 32'(disp), 32'h0059);
        clear_go();

        // Out-of-range seconds 00:99 -> 00:98
        key_digit(4'd9);
        key_digit(4'd9);
        chk("entry_99", 32'(disp), 32'h0099);
        start_go();
        startn = 1'b1;
        repeat (4) step();
        chk("borrow_99", 32'(disp), 32'h0098);
        clear_go();

        // Door interlock at 00:05
        key_digit(4'd5);
        start_go();
        startn = 1'b1;
        step();
        step();
        door_closed = 1'b0;
        #1;
        chk("door_mag_comb", 32'(mag_on), 32'd0);
        chk("door_state_same", 32'(state), 32'd2);
        step();
        chk("door_pause", 32'(state), 32'd3);
        door_closed = 1'b1;
        step();
        step();
        chk("door_close_stays", 32'(state), 32'd3);
        chk("door_close_mag", 32'(mag_on), 32'd0);
        start_go();
        startn = 1'b1;
        chk("resume_cook", 32'(state), 32'd2);
        chk("resume_disp", 32'(disp), 32'h0005);
        // Tick phase was held at 3, so the very next edge is the terminal tick.
        step();
        chk("resume_phase", 32'(disp), 32'h0004);

        // Stop freezes time, clear returns to IDLE
        stopn = 1'b0;
        step();
        step();
        chk("stop_pause", 32'(state), 32'd3);
        repeat (6) step();
        chk("stop_frozen", 32'(disp), 32'h0004);
        stopn = 1'b1;
        step();
        clear_go();
        chk("pause_clear_state", 32'(state), 32'd0);
        chk("pause_clear_disp", 32'(disp), 32'h0000);

        // Held start with door open, then door closes while held
        key_digit(4'd2);
        door_closed = 1'b0;
        startn      = 1'b0;
        repeat (20) step();
        chk("held_door_open", 32'(state), 32'd1);
        door_closed = 1'b1;
        repeat (3) step();
        chk("held_door_closed", 32'(state), 32'd1);
        chk("held_mag", 32'(mag_on), 32'd0);
        startn = 1'b1;
        step();

        // Clear and start together
        startn = 1'b0;
        clearn = 1'b0;
        step();
        step();
        chk("clear_start_tie", 32'(state), 32'd0);
        startn = 1'b1;
        clearn = 1'b1;
        step();

        // Stop on the terminal tick of the last second, then start -> DONE
        key_digit(4'd1);
        start_go();
        startn = 1'b1;
        step();
        step();
        stopn = 1'b0;
        step();
        step();
        chk("stop_term_state", 32'(state), 32'd3);
        chk("stop_term_disp", 32'(disp), 32'h0000);
        stopn = 1'b1;
        step();
        start_go();
        startn = 1'b1;
        chk("pause_zero_done", 32'(state), 32'd4);
        stopn = 1'b0;
        step();
        step();
        chk("done_stop_idle", 32'(state), 32'd0);
        stopn = 1'b1;
        step();

        // Reset in the middle of a cook
        key_digit(4'd8);
        start_go();
        startn = 1'b1;
        step();
        step();
        chk("pre_rst_mag", 32'(mag_on), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_mag", 32'(mag_on), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_disp", 32'(disp), 32'h0000);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microwave_sequencer.md
# microwave_sequencer

Sequencing controller for the microwave oven's magnetron path. It accepts BCD cook-time entry from the keypad and runs a MM:SS countdown from a clock-derived one-second tick. It drives `mag_on` through a five-state cook FSM with a door interlock, and asserts `timer_done` for the magnetron and beeper logic. It sits between the keypad/door inputs and the magnetron enable and display.

## Interface
- `TICKS_PER_SEC`, 50_000_000, `clk` cycles per countdown second (≥2).
- `clk` in 1, system clock; all state changes on the rising edge.
- `rst` in 1, synchronous, active-high.
- `startn` in 1, start key, active-low level.
- `stopn` in 1, stop/pause key, active-low level.
- `clearn` in 1, clear key, active-low level.
- `door_closed` in 1, 1 = door latched.
- `digit_valid` in 1, one-cycle strobe qualifying `digit`.
- `digit` in 4, BCD key value; values > 9 are ignored.
- `mag_on` out 1, magnetron enable.
- `timer_done` out 1, high while in DONE.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each, remaining-time display in BCD.
- `state` out 3, encoding: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- Key events:
  - `startn`, `stopn` and `clearn` are registered once.
  - An event is a falling edge of the registered value (previous 1, current 0).
  - Holding a key produces exactly one event.
- Digit entry is a left shift of the display: `min_tens`←`min_ones`←`sec_tens`←`sec_ones`←`digit`.
  - Entry is accepted only in IDLE, SET and DONE. In DONE, all four digits are zeroed before the shift.
  - `sec_tens` may hold 6–9 after entry (e.g. 00:99).
- Countdown:
  - The tick counter runs 0..TICKS_PER_SEC-1, in COOK only.
  - It holds its value in PAUSE and clears on entry to IDLE or SET.
  - At the terminal count, the time decrements by one second.
  - Borrow from a zero `sec_ones` sets it to 9 and decrements `sec_tens`.
  - Borrow from seconds = 00 sets seconds to 59 and decrements the minutes pair.
  - The minutes pair borrows the same way; `min_ones` 0 becomes 9.
- FSM (clear event has top priority in every state):
  - IDLE: digits all 0.
    - Digit making the time nonzero → SET.
    - Digit 0 leaves the FSM in IDLE.
    - Start is ignored.
  - SET:
    - Digit → shift, stay in SET.
    - Start with `door_closed` = 1 → COOK.
    - Clear → IDLE, digits zeroed.
  - COOK:
    - Clear → IDLE.
    - Stop event or `door_closed` = 0 → PAUSE.
    - Otherwise, a decrement producing 00:00 → DONE.
    - Digits are ignored.
  - PAUSE:
    - Start with `door_closed` = 1 → COOK.
    - Clear → IDLE.
    - Digits and stop are ignored.
  - DONE:
    - Clear or stop → IDLE.
    - Digit → SET with the fresh entry.
    - Start is ignored.
- Outputs:
  - `mag_on` = (state == COOK) AND `door_closed`. The AND is combinational, so opening the door cuts the magnetron in the same cycle.
  - `timer_done` = (state == DONE).
- Reset values: `state` = IDLE, all digits 0, tick counter 0, key history registers 1, `mag_on` 0, `timer_done` 0.

## Timing
- Key latency:
  - A key falls before edge k and is registered at k.
  - The event is decoded in the cycle after k, and the state updates at edge k+1.
  - Example: `mag_on` rises after edge k+1 when the door is closed.
- `digit_valid` is sampled directly; the display updates on the same edge.
- Door open in COOK:
  - `mag_on` drops combinationally in the same cycle.
  - `state` = PAUSE at the next edge.
  - Closing the door again does not resume cooking; a new start event is required.
- Cook duration: from entry to COOK to DONE is exactly N×TICKS_PER_SEC cycles for N entered seconds, with no pause.
- Simultaneous events:
  - Clear and start together → IDLE.
  - Stop and terminal tick together in COOK → PAUSE, and the decrement is still applied.
  - If that decrement reaches 00:00, the next start → DONE immediately.
- `rst` asserted mid-COOK: `mag_on` is 0 after that edge and all state returns to its reset value.

## Test plan
- Reset then idle: `rst` high 2 cycles → `state` = 0, digits 0000, `mag_on` = 0, `timer_done` = 0; start with the door closed leaves `state` at 0.
- Entry and cook (TICKS_PER_SEC = 4):
  - Enter 0, 0, 0, 3, door closed, start → COOK.
  - `mag_on` is high for 12 cycles while the display steps 00:03, 00:02, 00:01, 00:00.
  - Then DONE, `timer_done` = 1, `mag_on` = 0.
- Borrow: enter 1, 0, 0 (01:00) and cook 1 second → display reads 00:59. Enter 9, 9 (00:99) and cook 1 second → 00:98.
- Door interlock:
  - At 00:05 in COOK, drop `door_closed` → `mag_on` = 0 the same cycle, PAUSE next edge.
  - Close the door → stays in PAUSE.
  - Start → COOK, and the tick phase resumes where it stopped.
- Stop/clear: stop in COOK → PAUSE, time frozen; clear → IDLE with digits 0000. In DONE, digit 7 → SET reading 00:07.
- Held key and start with the door open: hold `startn` low 20 cycles in SET with `door_closed` = 0 → stays in SET; closing the door while the key is still held gives no COOK.
